// File: rtl/hex_display_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display: slot timing,
// dead time, brightness PWM, digit masking, leading-zero blanking, tear-free loads.
module hex_display_scan_ctrl #(
  parameter int SLOT_CYCLES = 8,
  parameter int DEAD_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  enable_mask,
  input  logic        lzb_en,
  input  logic [2:0]  brightness,
  output logic [7:0]  anodes,
  output logic [3:0]  digit_value,
  output logic [2:0]  digit_idx,
  output logic        frame_start
);

  localparam int SW      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int ON_SPAN = SLOT_CYCLES - DEAD_CYCLES;

  logic [SW-1:0] slot_cnt;
  logic [2:0]    dig;
  logic [31:0]   display_reg;
  logic [31:0]   shadow;
  logic          pending;

  logic          wrap_slot;
  logic          wrap_frame;
  logic [7:0]    lz;
  logic [31:0]   on_len;
  logic [31:0]   s32;
  logic          blank;
  logic          lit;

  // lz[k]: every nibble from digit 7 down to digit k is zero
  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_lz
      if (k == 7) begin : g_top
        assign lz[k] = (display_reg[4*k+3:4*k] == 4'd0);
      end else begin : g_chain
        assign lz[k] = lz[k+1] & (display_reg[4*k+3:4*k] == 4'd0);
      end
    end
  endgenerate

  assign wrap_slot  = (slot_cnt == SW'(SLOT_CYCLES - 1));
  assign wrap_frame = wrap_slot && (dig == 3'd7);
  assign s32        = 32'(slot_cnt);
  assign on_len     = (32'(ON_SPAN) * (32'(brightness) + 32'd1)) >> 3;
  assign blank      = !enable_mask[dig] || (lzb_en && lz[dig] && (dig != 3'd0));
  assign lit        = !blank && (s32 >= 32'(DEAD_CYCLES)) &&
                      (s32 < 32'(DEAD_CYCLES) + on_len);
  assign load_ready = !pending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      dig         <= 3'd0;
      display_reg <= 32'd0;
      shadow      <= 32'd0;
      pending     <= 1'b0;
      anodes      <= 8'hFF;
      digit_value <= 4'd0;
      digit_idx   <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= wrap_slot ? '0 : slot_cnt + SW'(1);
      if (wrap_slot) dig <= dig + 3'd1;

      // Commit and accept are exclusive: accept needs !pending, commit needs pending
      if (wrap_frame && pending) begin
        display_reg <= shadow;
        pending     <= 1'b0;
      end else if (load_valid && !pending) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end

      digit_idx   <= dig;
      digit_value <= display_reg[{dig, 2'b00} +: 4];
      frame_start <= (dig == 3'd0) && (slot_cnt == '0);
      anodes      <= lit ? ~(8'd1 << dig) : 8'hFF;
    end
  end

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Bench for hex_display_scan_ctrl: cycle scoreboard plus per-phase vector table
// and hand sequences for frame period and mid-frame reset.
module tb_hex_display_scan_ctrl;

  localparam int SLOT = 8;
  localparam int DEAD = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] value_in = 32'd0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  enable_mask = 8'hFF;
  logic        lzb_en = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  anodes;
  logic [3:0]  digit_value;
  logic [2:0]  digit_idx;
  logic        frame_start;

  hex_display_scan_ctrl #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
    .clock(clock), .reset(reset), .value_in(value_in), .load_valid(load_valid),
    .load_ready(load_ready), .enable_mask(enable_mask), .lzb_en(lzb_en),
    .brightness(brightness), .anodes(anodes), .digit_value(digit_value),
    .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] anodes;
    logic [3:0] dv;
    logic [2:0] idx;
    logic       fs;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  mask;
    logic        lzb;
    logic [2:0]  bright;
    int          exp_lit;
  } vec_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          lit_cnt = 0;
  int          m_dig = 0;
  int          m_slot = 0;
  logic [31:0] m_disp = 32'd0;
  logic [31:0] m_shadow = 32'd0;
  logic        m_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int   on_len;
    bit   shown;
    bit   any;
    e.idx    = m_dig[2:0];
    e.dv     = m_disp[m_dig*4 +: 4];
    e.fs     = (m_dig == 0) && (m_slot == 0);
    e.rdy    = 1'b0;
    on_len   = (SLOT - DEAD) * (int'(brightness) + 1) / 8;
    shown    = enable_mask[m_dig];
    if (lzb_en && m_dig != 0) begin
      any = 0;
      for (int k = m_dig; k < 8; k++) if (m_disp[k*4 +: 4] != 4'd0) any = 1;
      if (!any) shown = 0;
    end
    e.anodes = 8'hFF;
    if (shown && m_slot >= DEAD && m_slot < DEAD + on_len) e.anodes[m_dig] = 1'b0;
    return e;
  endfunction

  task automatic step();
    exp_t e;
    e = predict();
    @(posedge clock);
    if (m_dig == 7 && m_slot == SLOT - 1 && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end else if (load_valid && !m_pend) begin
      m_shadow = value_in;
      m_pend   = 1'b1;
    end
    if (m_slot == SLOT - 1) begin
      m_slot = 0;
      m_dig  = (m_dig + 1) % 8;
    end else begin
      m_slot++;
    end
    e.rdy = !m_pend;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk("anodes", anodes, e.anodes);
    chk("digit_value", digit_value, e.dv);
    chk("digit_idx", digit_idx, e.idx);
    chk("frame_start", frame_start, e.fs);
    chk("load_ready", load_ready, e.rdy);
    if (anodes !== 8'hFF) lit_cnt++;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    step(); n++;
    while (frame_start !== 1'b1 && n < 200) begin step(); n++; end
    chk("frame_start_timeout", frame_start, 1);
  endtask

  task automatic load(input logic [31:0] v);
    value_in   = v;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("ready_drop", load_ready, 0);
  endtask

  vec_t vecs[6];
  int   n;
  bit   seen5;

  initial begin
    vecs[0] = '{32'h0012_3456, 8'hFF, 1'b0, 3'd7, 56};
    vecs[1] = '{32'h0001_2345, 8'hFF, 1'b1, 3'd7, 35};
    vecs[2] = '{32'h0000_0000, 8'hFF, 1'b1, 3'd7, 7};
    vecs[3] = '{32'h1234_5678, 8'hFF, 1'b0, 3'd3, 24};
    vecs[4] = '{32'h1234_5678, 8'hFF, 1'b0, 3'd0, 0};
    vecs[5] = '{32'h8765_4321, 8'hAA, 1'b0, 3'd7, 28};

    // reset state
    @(posedge clock); #1;
    chk("rst_anodes", anodes, 8'hFF);
    chk("rst_digit_value", digit_value, 0);
    chk("rst_digit_idx", digit_idx, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_load_ready", load_ready, 1);
    @(negedge clock);
    reset = 1'b1;

    // free-running scan and frame period
    repeat (10) step();
    wait_fs();
    n = 1;
    step();
    while (frame_start !== 1'b1 && n < 200) begin step(); n++; end
    chk("frame_period", n, 64);

    foreach (vecs[i]) begin
      enable_mask = vecs[i].mask;
      lzb_en      = vecs[i].lzb;
      brightness  = vecs[i].bright;
      repeat (20) step();
      load(vecs[i].value);
      wait_fs();
      chk("committed_ready", load_ready, 1);
      chk("first_digit", digit_value, {28'd0, vecs[i].value[3:0]});
      lit_cnt = 0;
      repeat (63) step();
      chk("lit_per_frame", lit_cnt, vecs[i].exp_lit);
    end

    // mid-frame reset with a pending value
    enable_mask = 8'hFF; lzb_en = 1'b0; brightness = 3'd7;
    repeat (5) step();
    load(32'hAAAA_AAAA);
    wait_fs();
    chk("commit_a", digit_value, 4'hA);
    repeat (5) step();
    load(32'h5555_5555);
    n = 0;
    while (anodes === 8'hFF && n < 20) begin step(); n++; end
    chk("lit_before_reset", (anodes != 8'hFF), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_anodes", anodes, 8'hFF);
    chk("async_reset_ready", load_ready, 1);
    chk("async_reset_idx", digit_idx, 0);
    @(posedge clock); #1;
    chk("held_reset_anodes", anodes, 8'hFF);
    @(negedge clock);
    reset = 1'b1;
    m_dig = 0; m_slot = 0; m_disp = 32'd0; m_shadow = 32'd0; m_pend = 1'b0;
    seen5 = 0;
    repeat (128) begin
      step();
      if (digit_value === 4'h5) seen5 = 1;
    end
    chk("discarded_value", seen5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scan_ctrl.md
Name: hex_display_scan_ctrl

Overview:
Scan controller for the 8-digit multiplexed 7-segment display.
- Owns the digit-scan sequence: slot timing, anti-ghosting dead time, brightness PWM, per-digit enable and leading-zero blanking.
- Accepts new 32-bit display values through a valid/ready handshake and applies them only at frame boundaries, so a frame is never torn.
- Feeds the existing hex-to-segment decoder, which turns digit_value into segments.

Parameters:
SLOT_CYCLES, 8, clock cycles per digit slot (board build overrides, e.g. 100000); must be greater than DEAD_CYCLES.
DEAD_CYCLES, 1, cycles at the start of each slot with all anodes off.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
value_in  in  32  new display value; digit k = value_in[4k+3:4k]
load_valid  in  1  value_in is valid
load_ready  out  1  controller can accept a value; equals !pending
enable_mask  in  8  bit k = 0 forces digit k dark; its slot time is still consumed
lzb_en  in  1  leading-zero blanking enable
brightness  in  3  duty level, 0 = dimmest, 7 = full
anodes  out  8  active-low digit enables; at most one bit low
digit_value  out  4  nibble of the digit currently being scanned
digit_idx  out  3  index of the digit currently being scanned
frame_start  out  1  one-cycle pulse at the start of each digit-0 slot

Behaviour:
- Reset (reset=0, asynchronous):
  - anodes=8'hFF, digit_value=0, digit_idx=0, frame_start=0.
  - display_reg=0, shadow=0, pending=0, so load_ready=1.
  - Internal slot_cnt=0, dig=0.
- Counters:
  - slot_cnt runs 0..SLOT_CYCLES-1 and wraps.
  - On each wrap, dig increments mod 8 (7 wraps to 0).
  - First cycle after reset release: (dig, slot_cnt) = (0, 0).
- Outputs are registered: in cycle t+1, outputs reflect the counter state (d, s) held in cycle t.
  - digit_idx = d.
  - digit_value = display_reg[4d+3:4d].
  - frame_start = 1 iff d=0 and s=0.
- On-time:
  - on_len = floor((SLOT_CYCLES-DEAD_CYCLES)*(brightness+1)/8).
  - Digit d is lit iff DEAD_CYCLES <= s < DEAD_CYCLES+on_len and d is not blanked.
  - Lit means anodes[d]=0 and all other anodes = 1; otherwise anodes = 8'hFF.
  - brightness is sampled every cycle; a change takes effect at the next cycle.
- Blanking: digit d is blanked if either condition holds.
  - enable_mask[d]=0.
  - lzb_en=1, every nibble from digit 7 down to d is 0, and d != 0. Digit 0 is never zero-blanked, so value 0 displays "0".
- Handshake:
  - A transfer occurs when load_valid and load_ready are both 1 on a rising edge; then shadow <= value_in and pending <= 1.
  - While pending=1, load_ready=0 and value_in is ignored.
- Frame commit:
  - On the cycle where the counters wrap from (7, SLOT_CYCLES-1) to (0, 0), if pending=1: display_reg <= shadow and pending <= 0.
  - The new value is visible from the first digit-0 output of the new frame.
  - If a transfer and a wrap coincide (pending was 0), the transfer sets pending and commits at the following frame.
- Reset mid-frame: anodes go to 8'hFF asynchronously; a pending value is discarded; scan restarts at digit 0.
- Full frame length = 8*SLOT_CYCLES cycles. frame_start period = 64 cycles at the defaults.

Test Plan:
1. Release reset with load_valid=0, enable_mask=8'hFF, brightness=7, lzb_en=0 -> anodes=8'hFF in the first output cycle (dead time). anodes=8'hFE for the next 7 cycles, then 8'hFF for 1 cycle, then 8'hFD for 7 cycles, and so on. frame_start pulses every 64 cycles. digit_value=0 throughout.
2. Mid-frame, pulse load_valid with value_in=32'h0012_3456 -> load_ready drops the next cycle. digit_value is unchanged until the next frame_start, then the scan reads 6,5,4,3,2,1,0,0 for digits 0..7. load_ready returns to 1 on the commit cycle.
3. lzb_en=1 with value 32'h0001_2345 committed -> digits 7, 6 and 5 keep anodes=8'hFF in their slots. Digits 4..0 light with nibbles 1,2,3,4,5. With value 0, only digit 0 lights, showing 0.
4. brightness=3 at the defaults -> on_len=3: each digit is lit for slot cycles 1..3, and anodes=8'hFF for cycles 0 and 4..7. brightness=0 gives on_len=0: anodes stay 8'hFF permanently.
5. enable_mask=8'b1010_1010 -> only digits 1, 3, 5 and 7 light. The frame is still 64 cycles, and digit_idx steps through all 8 values.
6. Load 32'hAAAA_AAAA, then assert reset=0 mid-frame while a second value is pending -> anodes=8'hFF immediately, without waiting for a clock edge. After release, display_reg=0, load_ready=1, and the pending value never appears.
